fft_output_buffer: RTL and testbench

Parametrised, double-buffered (ping-pong) FFT output buffer. Accepts one frame of `N_POINTS` complex-packed samples, written one per cycle by arbitrary index, optionally bit-reversed on write. Emits each completed frame as `N_POINTS/SAMPLES_PER_LINE` wide lines over a valid/ready stream toward the host write-back path. One bank fills while the other drains, so the FFT core never stalls on an idle reader unless both banks are full.

---
 rtl/fft_output_buffer_pkg.sv | 37 +++
 rtl/fft_output_buffer_if.sv | 39 +++
 rtl/fft_output_buffer_line_bank.sv | 39 +++
 rtl/fft_output_buffer.sv | 104 ++++++++++
 tb/tb_fft_output_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_output_buffer_pkg.sv
// ============================================================================
// Package : fft_buf_pkg
// Desc    : Shared helpers for the ping-pong FFT output buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_buf_pkg;

  // Samples carried by one output line.
  function automatic int spl_of(input int line_w, input int sample_w);
    return line_w / sample_w;
  endfunction

  function automatic int lines_of(input int n_points, input int line_w, input int sample_w);
    return n_points / (line_w / sample_w);
  endfunction

  // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[width-1-i] = v[i];
    return r;
  endfunction

  function automatic int line_of(input int pos, input int spl);
    return pos / spl;
  endfunction

  function automatic int slot_of(input int pos, input int spl);
    return pos % spl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_output_buffer_if.sv
// ============================================================================
// Interface : fft_output_buffer_if
// Desc      : Sample write port plus line-wide valid/ready output stream.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_output_buffer_if #(
  parameter int SAMPLE_W = 16,
  parameter int N_POINTS = 2048,
  parameter int LINE_W   = 512
);
  localparam int c_iw = $clog2(N_POINTS);
  localparam int c_lw = $clog2(N_POINTS / (LINE_W / SAMPLE_W));

  logic                wr_en;
  logic [c_iw-1:0]     wr_index;
  logic [SAMPLE_W-1:0] wr_data;
  logic                wr_last;
  logic                wr_ready;
  logic                out_valid;
  logic                out_ready;
  logic [LINE_W-1:0]   out_data;
  logic [c_lw-1:0]     out_line;
  logic                out_last;
  logic                overflow;

  modport master (
    output wr_en, wr_index, wr_data, wr_last, out_ready,
    input  wr_ready, out_valid, out_data, out_line, out_last, overflow
  );

  modport slave (
    input  wr_en, wr_index, wr_data, wr_last, out_ready,
    output wr_ready, out_valid, out_data, out_line, out_last, overflow
  );
endinterface

`default_nettype wire

// File: rtl/fft_output_buffer_line_bank.sv
// ============================================================================
// Module : fft_line_bank
// Desc   : One frame bank; written a sample at a time, read a line at a time.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_line_bank
  import fft_buf_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int N_POINTS = 2048,
  parameter int LINE_W   = 512
) (
  input  wire logic                                         clk,
  input  wire logic                                         i_wr_en,
  input  wire logic [$clog2(lines_of(N_POINTS, LINE_W, SAMPLE_W))-1:0] i_wr_line,
  input  wire logic [$clog2(spl_of(LINE_W, SAMPLE_W))-1:0]  i_wr_slot,
  input  wire logic [SAMPLE_W-1:0]                          i_wr_data,
  input  wire logic [$clog2(lines_of(N_POINTS, LINE_W, SAMPLE_W))-1:0] i_rd_line,
  output logic      [LINE_W-1:0]                            o_rd_data
);
  localparam int c_spl   = spl_of(LINE_W, SAMPLE_W);
  localparam int c_lines = lines_of(N_POINTS, LINE_W, SAMPLE_W);

  // Storage carries no reset: stale contents are harmless once a bank is closed.
  logic [SAMPLE_W-1:0] r_mem [c_lines][c_spl];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_line][i_wr_slot] <= i_wr_data;
  end

  for (genvar k = 0; k < c_spl; k++) begin : g_slot
    assign o_rd_data[k*SAMPLE_W +: SAMPLE_W] = r_mem[i_rd_line][k];
  end

endmodule

`default_nettype wire

// File: rtl/fft_output_buffer.sv
// ============================================================================
// Module : fft_output_buffer
// Desc   : Ping-pong FFT frame buffer emitting completed frames as wide lines.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_output_buffer
  import fft_buf_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int N_POINTS    = 2048,
  parameter int LINE_W      = 512,
  parameter int BIT_REVERSE = 0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  fft_output_buffer_if.slave bus
);
  localparam int c_spl   = spl_of(LINE_W, SAMPLE_W);
  localparam int c_lines = lines_of(N_POINTS, LINE_W, SAMPLE_W);
  localparam int c_iw    = $clog2(N_POINTS);
  localparam int c_lw    = $clog2(c_lines);
  localparam int c_sw    = $clog2(c_spl);

  logic [1:0]      r_bank_full;
  logic            r_wb;
  logic            r_rb;
  logic [c_lw-1:0] r_rd_line;
  logic            r_overflow;

  logic            w_wr_ready;
  logic            w_wr_acc;
  logic            w_fill_close;
  logic            w_out_valid;
  logic            w_beat;
  logic            w_drain_close;
  logic [c_iw-1:0] w_pos;
  logic [c_lw-1:0] w_wr_line;
  logic [c_sw-1:0] w_wr_slot;
  logic [LINE_W-1:0] w_bank_rd [2];

  assign w_wr_ready    = !r_bank_full[r_wb];
  assign w_wr_acc      = bus.wr_en && w_wr_ready;
  assign w_fill_close  = w_wr_acc && bus.wr_last;
  assign w_out_valid   = r_bank_full[r_rb];
  assign w_beat        = w_out_valid && bus.out_ready;
  assign w_drain_close = w_beat && (r_rd_line == c_lw'(c_lines - 1));

  assign w_pos     = (BIT_REVERSE != 0) ? c_iw'(bitrev(32'(bus.wr_index), c_iw)) : bus.wr_index;
  assign w_wr_line = c_lw'(line_of(int'(w_pos), c_spl));
  assign w_wr_slot = c_sw'(slot_of(int'(w_pos), c_spl));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_line_bank #(
      .SAMPLE_W (SAMPLE_W),
      .N_POINTS (N_POINTS),
      .LINE_W   (LINE_W)
    ) u_bank (
      .clk       (clk),
      .i_wr_en   (w_wr_acc && (r_wb == 1'(b))),
      .i_wr_line (w_wr_line),
      .i_wr_slot (w_wr_slot),
      .i_wr_data (bus.wr_data),
      .i_rd_line (r_rd_line),
      .o_rd_data (w_bank_rd[b])
    );
  end

  // A fill-close and a drain-close in the same cycle always target different
  // banks (writing is blocked while the read bank is the write bank and full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_rd_line   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.wr_en && !w_wr_ready) r_overflow <= 1'b1;
      if (w_fill_close) begin
        r_bank_full[r_wb] <= 1'b1;
        r_wb              <= ~r_wb;
      end
      if (w_drain_close) begin
        r_bank_full[r_rb] <= 1'b0;
        r_rb              <= ~r_rb;
        r_rd_line         <= '0;
      end else if (w_beat) begin
        r_rd_line <= r_rd_line + c_lw'(1);
      end
    end
  end

  assign bus.wr_ready  = w_wr_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_bank_rd[r_rb] : '0;
  assign bus.out_line  = r_rd_line;
  assign bus.out_last  = (r_rd_line == c_lw'(c_lines - 1));
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fft_output_buffer.sv
// ============================================================================
// Module : tb_fft_output_buffer
// Desc   : Drives a natural-order and a bit-reversed buffer in lockstep against a frame-queue model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_output_buffer;
  localparam int NP    = 2048;
  localparam int SPL   = 32;
  localparam int LINES = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_output_buffer_if #(.SAMPLE_W(16), .N_POINTS(NP), .LINE_W(512)) bus0();
  fft_output_buffer_if #(.SAMPLE_W(16), .N_POINTS(NP), .LINE_W(512)) bus1();

  fft_output_buffer #(.SAMPLE_W(16), .N_POINTS(NP), .LINE_W(512), .BIT_REVERSE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fft_output_buffer #(.SAMPLE_W(16), .N_POINTS(NP), .LINE_W(512), .BIT_REVERSE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef logic [15:0] frame_t [NP];

  // Model: queue of completed frames (sample-position images) for each DUT.
  frame_t q0[$];
  frame_t q1[$];
  frame_t cur0, cur1;
  int     m_line;
  bit     m_ovf;
  int     n_checks;
  int     n_fail;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < 11; i++) if (((v >> i) & 1) != 0) r = r | (1 << (10 - i));
    return r;
  endfunction

  task automatic drive(input bit we, input int idx, input logic [15:0] d, input bit last, input bit rdy);
    bus0.wr_en = we; bus0.wr_index = 11'(idx); bus0.wr_data = d; bus0.wr_last = last; bus0.out_ready = rdy;
    bus1.wr_en = we; bus1.wr_index = 11'(idx); bus1.wr_data = d; bus1.wr_last = last; bus1.out_ready = rdy;
  endtask

  // One clock: drive at posedge+1, compare every output at negedge, step model.
  task automatic cycle(input bit we, input int idx, input logic [15:0] d, input bit last, input bit rdy);
    logic [511:0] e0, e1;
    bit ev, acc, el;
    drive(we, idx, d, last, rdy);
    @(negedge clk);
    ev = (q0.size() != 0);
    el = (m_line == LINES - 1);
    e0 = '0; e1 = '0;
    if (ev) for (int k = 0; k < SPL; k++) begin
      e0[k*16 +: 16] = q0[0][m_line*SPL + k];
      e1[k*16 +: 16] = q1[0][m_line*SPL + k];
    end
    n_checks++;
    if (bus0.out_valid !== ev || bus1.out_valid !== ev) begin
      n_fail++; $display("FAIL out_valid: got %b/%b want %b", bus0.out_valid, bus1.out_valid, ev);
    end
    n_checks++;
    if (bus0.out_data !== e0) begin
      n_fail++; $display("FAIL out_data natural line %0d: got %h want %h", m_line, bus0.out_data, e0);
    end
    n_checks++;
    if (bus1.out_data !== e1) begin
      n_fail++; $display("FAIL out_data bitrev line %0d: got %h want %h", m_line, bus1.out_data, e1);
    end
    n_checks++;
    if (bus0.out_line !== 6'(m_line) || bus1.out_line !== 6'(m_line) || bus0.out_last !== el || bus1.out_last !== el) begin
      n_fail++; $display("FAIL out_line/last: got %0d/%0d last %b/%b want %0d last %b",
                         bus0.out_line, bus1.out_line, bus0.out_last, bus1.out_last, m_line, el);
    end
    n_checks++;
    if (bus0.wr_ready !== (q0.size() < 2) || bus1.wr_ready !== (q0.size() < 2)
        || bus0.overflow !== m_ovf || bus1.overflow !== m_ovf) begin
      n_fail++; $display("FAIL wr_ready/overflow: got %b/%b ovf %b/%b want %b ovf %b",
                         bus0.wr_ready, bus1.wr_ready, bus0.overflow, bus1.overflow, q0.size() < 2, m_ovf);
    end
    acc = we && (q0.size() < 2);
    if (we && !acc) m_ovf = 1'b1;
    if (ev && rdy) begin
      if (m_line == LINES - 1) begin q0.delete(0); q1.delete(0); m_line = 0; end
      else m_line++;
    end
    if (acc) begin
      cur0[idx] = d;
      cur1[brev(idx)] = d;
      if (last) begin q0.push_back(cur0); q1.push_back(cur1); end
    end
    @(posedge clk); #1;
  endtask

  // mode 0: data = index + base, mode 1: random data
  task automatic write_frame(input bit mode, input int base, input bit rdy);
    for (int i = 0; i < NP; i++)
      cycle(1'b1, i, mode ? 16'($urandom) : 16'(i + base), i == NP - 1, rdy);
  endtask

  task automatic drain(input int n, input bit rand_rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 16'h0, 1'b0, rand_rdy ? 1'($urandom) : 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0 || bus0.out_data !== '0 || bus1.out_data !== '0
        || bus0.out_line !== 6'd0 || bus0.out_last !== 1'b0 || bus0.wr_ready !== 1'b1
        || bus1.wr_ready !== 1'b1 || bus0.overflow !== 1'b0 || bus1.overflow !== 1'b0) begin
      n_fail++; $display("FAIL %s: got valid %b data0 %h line %0d last %b rdy %b ovf %b, want reset values",
                         tag, bus0.out_valid, bus0.out_data[63:0], bus0.out_line, bus0.out_last,
                         bus0.wr_ready, bus0.overflow);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); m_line = 0; m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    drain(2, 1'b0);
  endtask

  task automatic test_linear();
    write_frame(1'b0, 0, 1'b1);
    n_checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_line !== 6'd0 || bus0.out_data[31*16 +: 16] !== 16'd31
        || bus0.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL linear_first_line: got valid %b line %0d slot31 %0d rdy %b want 1 0 31 1",
                         bus0.out_valid, bus0.out_line, bus0.out_data[31*16 +: 16], bus0.wr_ready);
    end
    n_checks++;
    if (bus1.out_data[1*16 +: 16] !== 16'd1024 || bus1.out_data[2*16 +: 16] !== 16'd512) begin
      n_fail++; $display("FAIL bitrev_line0: got slot1 %0d slot2 %0d want 1024 512",
                         bus1.out_data[1*16 +: 16], bus1.out_data[2*16 +: 16]);
    end
    drain(LINES - 1, 1'b0);
    n_checks++;
    if (bus0.out_last !== 1'b1 || bus0.out_data[15:0] !== 16'd2016 || bus1.out_data[31*16 +: 16] !== 16'd2047) begin
      n_fail++; $display("FAIL line63: got last %b slot0 %0d rev_slot31 %0d want 1 2016 2047",
                         bus0.out_last, bus0.out_data[15:0], bus1.out_data[31*16 +: 16]);
    end
    drain(1, 1'b0);
    n_checks++;
    if (bus0.out_valid !== 1'b0 || bus0.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL linear_done: got valid %b rdy %b want 0 1", bus0.out_valid, bus0.wr_ready);
    end
  endtask

  task automatic test_random_frame();
    write_frame(1'b1, 0, 1'b1);
    drain(LINES + 2, 1'b0);
  endtask

  task automatic test_overflow();
    write_frame(1'b0, 0, 1'b0);
    write_frame(1'b0, 32'h1000, 1'b0);
    n_checks++;
    if (bus0.wr_ready !== 1'b0 || bus1.wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL both_full_wr_ready: got %b/%b want 0", bus0.wr_ready, bus1.wr_ready);
    end
    cycle(1'b1, int'($urandom_range(0, NP - 1)), 16'($urandom), 1'b0, 1'b0);
    n_checks++;
    if (bus0.overflow !== 1'b1 || bus1.overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_set: got %b/%b want 1", bus0.overflow, bus1.overflow);
    end
    drain(2 * LINES + 2, 1'b0);
  endtask

  task automatic test_stall();
    int beats = 0;
    int guard = 0;
    bit rdy;
    write_frame(1'b1, 0, 1'b0);
    while (q0.size() != 0 && guard < 1000) begin
      rdy = 1'($urandom);
      if (bus0.out_valid === 1'b1 && rdy) beats++;
      cycle(1'b0, 0, 16'h0, 1'b0, rdy);
      guard++;
    end
    n_checks++;
    if (beats != LINES || guard >= 1000) begin
      n_fail++; $display("FAIL stall_beats: got %0d beats in %0d cycles want %0d", beats, guard, LINES);
    end
  endtask

  task automatic test_back_to_back();
    write_frame(1'b1, 0, 1'b0);
    for (int i = 0; i < NP - 1; i++) cycle(1'b1, i, 16'($urandom), 1'b0, 1'b0);
    drain(LINES - 1, 1'b0);
    cycle(1'b1, NP - 1, 16'($urandom), 1'b1, 1'b1);
    n_checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_line !== 6'd0 || bus0.wr_ready !== 1'b1 || bus1.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL back_to_back: got valid %b line %0d rdy %b want 1 0 1",
                         bus0.out_valid, bus0.out_line, bus0.wr_ready);
    end
    drain(LINES + 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    write_frame(1'b1, 0, 1'b1);
    drain(20, 1'b0);
    n_checks++;
    if (bus0.out_line !== 6'd20 || bus0.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_line: got %0d valid %b want 20 1", bus0.out_line, bus0.out_valid);
    end
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    write_frame(1'b1, 0, 1'b1);
    drain(LINES + 1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_line   = 0;
    m_ovf    = 1'b0;
    test_reset();
    test_linear();
    test_random_frame();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
